ppu_pixel_fifo: RTL and testbench

- Parametrised successor to the PPU's fixed 8-pixel, 2-plane shift register.
- Holds up to DEPTH background pixels and a per-entry sprite overlay.
- Supports fine-scroll discard (SCX[2:0]) at line start, merges fetched sprite rows into the head of the queue, and applies BGP/OBP0/OBP1 palette mapping.
- Sits between the BG/sprite fetch machines and the LCD pixel output.

---
 rtl/ppu_pixel_fifo.sv | 159 +++++++++++++++
 tb/tb_ppu_pixel_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_pixel_fifo.sv
// Background pixel FIFO with per-entry sprite overlay, fine-scroll discard and palette mixing.
// Tile rows are pushed at the tail and sprite rows are merged into the head window.
module ppu_pixel_fifo #(
    parameter int DEPTH  = 16,
    parameter int TILE_W = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [2:0]        discard,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [TILE_W-1:0] push_lo,
    input  logic [TILE_W-1:0] push_hi,
    input  logic              sp_valid,
    output logic              sp_ready,
    input  logic [TILE_W-1:0] sp_lo,
    input  logic [TILE_W-1:0] sp_hi,
    input  logic              sp_pal,
    input  logic              sp_prio,
    input  logic              pop_en,
    input  logic              bg_en,
    input  logic [7:0]        bgp,
    input  logic [7:0]        obp0,
    input  logic [7:0]        obp1,
    output logic [1:0]        px_out,
    output logic              px_valid,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LANE_W = $clog2(TILE_W);
    localparam logic [PTR_W-1:0] TILE_P = PTR_W'(TILE_W);
    localparam logic [CNT_W-1:0] TILE_C = CNT_W'(TILE_W);
    localparam logic [CNT_W-1:0] ROOM_C = CNT_W'(DEPTH - TILE_W);

    logic [1:0]       bg_mem   [DEPTH];
    logic [1:0]       sp_mem   [DEPTH];
    logic             pal_mem  [DEPTH];
    logic             prio_mem [DEPTH];

    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [2:0]       disc_reg;
    logic [1:0]       px_out_reg;
    logic             px_valid_reg;

    logic             push_fire, merge_fire, pop_fire;
    logic [1:0]       shade_next;

    // Lane-reversed copies so lane 0 is the leftmost pixel.
    logic [TILE_W-1:0] push_lo_r, push_hi_r, sp_lo_r, sp_hi_r;

    logic [PTR_W-1:0] push_off  [DEPTH];
    logic [PTR_W-1:0] merge_off [DEPTH];
    logic             push_win  [DEPTH];
    logic             merge_hit [DEPTH];
    logic [1:0]       push_bg   [DEPTH];
    logic [1:0]       merge_sp  [DEPTH];

    assign push_ready = (count_reg <= ROOM_C);
    assign sp_ready   = (count_reg >= TILE_C) && !pop_en;
    assign push_fire  = push_valid && push_ready;
    assign merge_fire = sp_valid && sp_ready;
    assign pop_fire   = pop_en && (count_reg != '0);

    assign px_out   = px_out_reg;
    assign px_valid = px_valid_reg;
    assign count    = count_reg;

    generate
        for (genvar gi = 0; gi < TILE_W; gi++) begin : g_lane
            assign push_lo_r[gi] = push_lo[TILE_W-1-gi];
            assign push_hi_r[gi] = push_hi[TILE_W-1-gi];
            assign sp_lo_r[gi]   = sp_lo[TILE_W-1-gi];
            assign sp_hi_r[gi]   = sp_hi[TILE_W-1-gi];
        end

        // Each entry's distance from tail/head tells whether it lies in the push or merge window.
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign push_off[gi]  = PTR_W'(gi) - tail_reg;
            assign merge_off[gi] = PTR_W'(gi) - head_reg;
            assign push_win[gi]  = (push_off[gi] < TILE_P);
            assign push_bg[gi]   = {push_hi_r[push_off[gi][LANE_W-1:0]],
                                    push_lo_r[push_off[gi][LANE_W-1:0]]};
            assign merge_sp[gi]  = {sp_hi_r[merge_off[gi][LANE_W-1:0]],
                                    sp_lo_r[merge_off[gi][LANE_W-1:0]]};
            assign merge_hit[gi] = (merge_off[gi] < TILE_P) && (sp_mem[gi] == 2'd0)
                                   && (merge_sp[gi] != 2'd0);
        end
    endgenerate

    // Push and merge windows never overlap: both can fire only at count == TILE_W.
    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_fire && push_win[i]) begin
                    bg_mem[i]   <= push_bg[i];
                    sp_mem[i]   <= 2'd0;
                    pal_mem[i]  <= 1'b0;
                    prio_mem[i] <= 1'b0;
                end else if (merge_fire && merge_hit[i]) begin
                    sp_mem[i]   <= merge_sp[i];
                    pal_mem[i]  <= sp_pal;
                    prio_mem[i] <= sp_prio;
                end
            end
        end
    end

    always_comb begin
        logic [1:0] b;
        logic [7:0] obp_sel;
        b          = bg_en ? bg_mem[head_reg] : 2'd0;
        obp_sel    = pal_mem[head_reg] ? obp1 : obp0;
        shade_next = bgp[{b, 1'b0} +: 2];
        if (sp_mem[head_reg] != 2'd0 && !(prio_mem[head_reg] && b != 2'd0))
            shade_next = obp_sel[{sp_mem[head_reg], 1'b0} +: 2];
    end

    always_comb begin
        count_next = count_reg;
        if (push_fire)
            count_next = count_next + TILE_C;
        if (pop_fire)
            count_next = count_next - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            disc_reg     <= '0;
            px_out_reg   <= 2'd0;
            px_valid_reg <= 1'b0;
        end else if (clear) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            disc_reg     <= discard;
            px_valid_reg <= 1'b0;
        end else begin
            px_valid_reg <= 1'b0;
            count_reg    <= count_next;
            if (push_fire)
                tail_reg <= tail_reg + TILE_P;
            if (pop_fire) begin
                head_reg <= head_reg + PTR_W'(1);
                if (disc_reg != 3'd0) begin
                    disc_reg <= disc_reg - 3'd1;
                end else begin
                    px_valid_reg <= 1'b1;
                    px_out_reg   <= shade_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Directed and random stimulus for ppu_pixel_fifo, checked against a queue-based pixel model.
module tb_ppu_pixel_fifo;
    localparam int DEPTH  = 16;
    localparam int TILE_W = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, clear, push_valid, push_ready, sp_valid, sp_ready;
    logic              sp_pal, sp_prio, pop_en, bg_en, px_valid;
    logic [2:0]        discard;
    logic [TILE_W-1:0] push_lo, push_hi, sp_lo, sp_hi;
    logic [7:0]        bgp, obp0, obp1;
    logic [1:0]        px_out;
    logic [CNT_W-1:0]  count;

    ppu_pixel_fifo #(.DEPTH(DEPTH), .TILE_W(TILE_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .discard(discard),
        .push_valid(push_valid), .push_ready(push_ready), .push_lo(push_lo), .push_hi(push_hi),
        .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_lo(sp_lo), .sp_hi(sp_hi),
        .sp_pal(sp_pal), .sp_prio(sp_prio), .pop_en(pop_en), .bg_en(bg_en),
        .bgp(bgp), .obp0(obp0), .obp1(obp1),
        .px_out(px_out), .px_valid(px_valid), .count(count)
    );

    typedef struct packed {
        logic [1:0] bg;
        logic [1:0] sp;
        logic       pal;
        logic       prio;
    } ent_t;

    ent_t       q[$];
    int         disc_m;
    logic       exp_valid;
    logic [1:0] exp_px;
    int         checks = 0;
    int         errors = 0;
    int         valid_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] shade_of(input ent_t e);
        int b;
        int pal_byte;
        b = bg_en ? int'(e.bg) : 0;
        if (e.sp != 0 && !(e.prio && b != 0)) begin
            pal_byte = e.pal ? int'(obp1) : int'(obp0);
            return 2'((pal_byte >> (2 * e.sp)) & 3);
        end
        return 2'((int'(bgp) >> (2 * b)) & 3);
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic tick();
        int   n;
        logic pr, spr;
        ent_t e;
        logic [1:0] s;
        #1;
        n   = q.size();
        pr  = (n <= DEPTH - TILE_W);
        spr = (n >= TILE_W) && !pop_en;
        chk("count", count, n);
        chk("push_ready", push_ready, pr);
        chk("sp_ready", sp_ready, spr);
        if (rst) begin
            q.delete(); disc_m = 0; exp_valid = 0; exp_px = 0;
        end else if (clear) begin
            q.delete(); disc_m = discard; exp_valid = 0;
        end else begin
            exp_valid = 0;
            if (sp_valid && spr) begin
                for (int i = 0; i < TILE_W; i++) begin
                    s = {sp_hi[TILE_W-1-i], sp_lo[TILE_W-1-i]};
                    e = q[i];
                    if (e.sp == 0 && s != 0) begin
                        e.sp = s; e.pal = sp_pal; e.prio = sp_prio;
                        q[i] = e;
                    end
                end
            end
            if (pop_en && n > 0) begin
                e = q.pop_front();
                if (disc_m > 0) disc_m--;
                else begin exp_valid = 1; exp_px = shade_of(e); end
            end
            if (push_valid && pr) begin
                for (int i = 0; i < TILE_W; i++) begin
                    e.bg = {push_hi[TILE_W-1-i], push_lo[TILE_W-1-i]};
                    e.sp = 0; e.pal = 0; e.prio = 0;
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        chk("px_valid", px_valid, exp_valid);
        chk("px_out", px_out, exp_px);
        if (px_valid) valid_seen++;
        $display("t=%0t rst=%0b clr=%0b push=%0b pop=%0b sp=%0b -> count=%0d px_valid=%0b px_out=%0d",
                 $time, rst, clear, push_valid, pop_en, sp_valid, count, px_valid, px_out);
    endtask

    task automatic idle();
        rst = 0; clear = 0; push_valid = 0; sp_valid = 0; pop_en = 0;
    endtask

    task automatic do_clear(input logic [2:0] d);
        idle(); clear = 1; discard = d; tick(); clear = 0;
    endtask

    task automatic push_row(input logic [7:0] lo, input logic [7:0] hi);
        push_valid = 1; push_lo = lo; push_hi = hi; tick(); push_valid = 0;
    endtask

    task automatic merge_row(input logic [7:0] lo, input logic [7:0] hi, input logic pal, input logic prio);
        sp_valid = 1; sp_lo = lo; sp_hi = hi; sp_pal = pal; sp_prio = prio; tick(); sp_valid = 0;
    endtask

    int exp_seq[8] = '{3, 1, 3, 1, 2, 0, 2, 0};

    initial begin
        idle(); rst = 1; discard = 0; push_lo = 0; push_hi = 0; sp_lo = 0; sp_hi = 0;
        sp_pal = 0; sp_prio = 0; bg_en = 1; bgp = 8'hE4; obp0 = 8'h00; obp1 = 8'h00;
        q.delete(); disc_m = 0; exp_valid = 0; exp_px = 0; valid_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        tick();
        chk("reset_px_out", px_out, 0);
        chk("reset_px_valid", px_valid, 0);
        idle();

        // Basic tile row, no discard.
        do_clear(3'd0);
        push_row(8'hF0, 8'hAA);
        pop_en = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("seq_valid", px_valid, 1);
            chk("seq_px", px_out, exp_seq[i]);
        end
        pop_en = 0; tick();
        chk("seq_count_end", count, 0);

        // Fine-scroll discard of 3.
        do_clear(3'd3);
        push_row(8'h3C, 8'h5A);
        push_row(8'hC3, 8'hA5);
        pop_en = 1; valid_seen = 0;
        repeat (16) tick();
        chk("discard_valid_count", valid_seen, 13);
        pop_en = 0; tick();

        // Fill, overflow drop, drain, simultaneous push+pop.
        do_clear(3'd0);
        push_row(8'h12, 8'h34);
        push_row(8'h56, 8'h78);
        push_row(8'h9A, 8'hBC);
        chk("full_count", count, 16);
        pop_en = 1; tick();
        chk("ready_at_15", push_ready, 0);
        repeat (7) tick();
        pop_en = 0; tick();
        chk("ready_at_8", push_ready, 1);
        pop_en = 1; push_row(8'hDE, 8'hAD); pop_en = 0;
        chk("push_pop_count", count, 15);
        tick();

        // Sprite merge over colour 1, then priority, then first sprite wins.
        obp0 = 8'hFF; obp1 = 8'h0C; bgp = 8'hE4;
        do_clear(3'd0);
        push_row(8'hFF, 8'h00);
        merge_row(8'hFF, 8'h00, 1'b1, 1'b0);
        merge_row(8'h00, 8'hFF, 1'b0, 1'b0);
        pop_en = 1;
        for (int i = 0; i < 8; i++) begin tick(); chk("sprite_front", px_out, 3); end
        pop_en = 0;
        push_row(8'hFF, 8'h00);
        merge_row(8'hFF, 8'h00, 1'b1, 1'b1);
        pop_en = 1;
        for (int i = 0; i < 8; i++) begin tick(); chk("sprite_behind", px_out, 1); end
        pop_en = 0;

        // Merge blocked while popping; bg_en=0 forces colour 0.
        push_row(8'h00, 8'hFF);
        pop_en = 1; sp_valid = 1; sp_lo = 8'hFF; sp_hi = 8'hFF;
        tick();
        chk("merge_blocked_ready", sp_ready, 0);
        sp_valid = 0;
        bgp = 8'h1B; bg_en = 0;
        tick();
        chk("bg_disabled", px_out, 3);
        bg_en = 1; pop_en = 0;

        // Mid-line clear during a push, then reset during a pop.
        do_clear(3'd0);
        push_row(8'h0F, 8'hF0);
        push_row(8'hFF, 8'h0F);
        pop_en = 1; repeat (4) tick(); pop_en = 0;
        chk("count_12", count, 12);
        push_valid = 1; clear = 1; pop_en = 1; tick();
        chk("midline_clear_count", count, 0);
        chk("midline_clear_valid", px_valid, 0);
        idle();
        push_row(8'h5A, 8'hA5);
        pop_en = 1; tick();
        rst = 1; tick();
        chk("rst_count", count, 0);
        chk("rst_px_out", px_out, 0);
        chk("rst_px_valid", px_valid, 0);
        idle();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 499) == 0);
            clear      = ($urandom_range(0, 49) == 0);
            discard    = 3'($urandom);
            push_valid = $urandom_range(0, 1);
            push_lo    = 8'($urandom); push_hi = 8'($urandom);
            pop_en     = ($urandom_range(0, 9) < 6);
            sp_valid   = ($urandom_range(0, 9) < 3);
            sp_lo      = 8'($urandom); sp_hi = 8'($urandom);
            sp_pal     = $urandom_range(0, 1); sp_prio = $urandom_range(0, 1);
            bg_en      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) begin
                bgp = 8'($urandom); obp0 = 8'($urandom); obp1 = 8'($urandom);
            end
            tick();
        end
        idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
